// File: rtl/vending_machine.sv
// Three-beverage coin vending controller: credit accumulation, selection, dispense pulse, greedy change.
// Optional macro VENDING_MULTI_COIN_EN: sum all coins seen in one cycle instead of accepting one by priority.
module vending_machine #(
  parameter int PRICE1   = 100,
  parameter int PRICE2   = 120,
  parameter int PRICE3   = 115,
  parameter int CREDIT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inbev1,
  input  logic inbev2,
  input  logic inbev3,
  input  logic inquarter,
  input  logic indime,
  input  logic innickel,
  output logic outbev1,
  output logic outbev2,
  output logic outbev3,
  output logic outquarter,
  output logic outdime,
  output logic outnickel
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DISPENSE = 2'd1, ST_CHANGE = 2'd2} state_t;
  typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_B1 = 2'd1, SEL_B2 = 2'd2, SEL_B3 = 2'd3} sel_t;

  localparam logic [CREDIT_W-1:0] P1  = CREDIT_W'(PRICE1);
  localparam logic [CREDIT_W-1:0] P2  = CREDIT_W'(PRICE2);
  localparam logic [CREDIT_W-1:0] P3  = CREDIT_W'(PRICE3);
  localparam logic [CREDIT_W-1:0] V_Q = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] V_D = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] V_N = CREDIT_W'(5);

  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                 input logic [CREDIT_W-1:0] b);
    logic [CREDIT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[CREDIT_W]) sat_add = '1;
    else             sat_add = s[CREDIT_W-1:0];
  endfunction

  // Coin code is {quarter, dime, nickel}; largest coin that fits the amount
  function automatic logic [2:0] greedy_code(input logic [CREDIT_W-1:0] amt);
    if (amt >= V_Q)      greedy_code = 3'b100;
    else if (amt >= V_D) greedy_code = 3'b010;
    else                 greedy_code = 3'b001;
  endfunction

  function automatic logic [CREDIT_W-1:0] coin_val(input logic [2:0] code);
    case (code)
      3'b100:  coin_val = V_Q;
      3'b010:  coin_val = V_D;
      default: coin_val = V_N;
    endcase
  endfunction

  state_t              r_state;
  sel_t                r_sel;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_change;
  logic [2:0]          r_outbev;
  logic [2:0]          r_outcoin;

  state_t              w_state_nxt;
  sel_t                w_sel_nxt;
  sel_t                w_req;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [CREDIT_W-1:0] w_change_nxt;
  logic [CREDIT_W-1:0] w_coin;
  logic [CREDIT_W-1:0] w_price;
  logic [CREDIT_W-1:0] w_cval;
  logic [2:0]          w_bev_nxt;
  logic [2:0]          w_outcoin_nxt;

  // Value of coins presented this cycle
  always_comb begin
`ifdef VENDING_MULTI_COIN_EN
    w_coin = (inquarter ? V_Q : '0) + (indime ? V_D : '0) + (innickel ? V_N : '0);
`else
    if (inquarter)     w_coin = V_Q;
    else if (indime)   w_coin = V_D;
    else if (innickel) w_coin = V_N;
    else               w_coin = '0;
`endif
  end

  // Selection request priority and price lookup for the latched selection
  always_comb begin
    if (inbev1)      w_req = SEL_B1;
    else if (inbev2) w_req = SEL_B2;
    else if (inbev3) w_req = SEL_B3;
    else             w_req = SEL_NONE;
    case (r_sel)
      SEL_B1:  w_price = P1;
      SEL_B2:  w_price = P2;
      SEL_B3:  w_price = P3;
      default: w_price = '0;
    endcase
    w_cval = coin_val(greedy_code(r_change));
  end

  // Next-state, next-data and next-output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = (w_req != SEL_NONE) ? w_req : r_sel;
    w_credit_nxt = sat_add(r_credit, w_coin);
    w_change_nxt = r_change;
    w_bev_nxt    = 3'b000;
    case (r_state)
      ST_IDLE: begin
        if ((r_sel != SEL_NONE) && (r_credit >= w_price)) begin
          w_state_nxt  = ST_DISPENSE;
          w_change_nxt = r_credit - w_price;
          w_credit_nxt = w_coin;
          w_sel_nxt    = w_req;
          w_bev_nxt    = {r_sel == SEL_B3, r_sel == SEL_B2, r_sel == SEL_B1};
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_DISPENSE: begin
        if (r_change != '0) w_state_nxt = ST_CHANGE;
        else                w_state_nxt = ST_IDLE;
      end
      ST_CHANGE: begin
        // Clamp at zero so an odd leftover can never wrap around
        if (r_change <= w_cval) begin
          w_change_nxt = '0;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_change_nxt = r_change - w_cval;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_change_nxt = '0;
      end
    endcase
    if (w_state_nxt == ST_CHANGE) w_outcoin_nxt = greedy_code(w_change_nxt);
    else                          w_outcoin_nxt = 3'b000;
  end

  // State, data and registered output flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_sel     <= SEL_NONE;
      r_credit  <= '0;
      r_change  <= '0;
      r_outbev  <= 3'b000;
      r_outcoin <= 3'b000;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_credit  <= w_credit_nxt;
      r_change  <= w_change_nxt;
      r_outbev  <= w_bev_nxt;
      r_outcoin <= w_outcoin_nxt;
    end
  end

  assign outbev1    = r_outbev[0];
  assign outbev2    = r_outbev[1];
  assign outbev3    = r_outbev[2];
  assign outquarter = r_outcoin[2];
  assign outdime    = r_outcoin[1];
  assign outnickel  = r_outcoin[0];

endmodule

// File: tb/tb_vending_machine.sv
// Directed table-driven bench for vending_machine plus hand sequences for reset abort,
// simultaneous coins, credit saturation and selection priority.
module tb_vending_machine;

  logic clk, reset;
  logic inbev1, inbev2, inbev3, inquarter, indime, innickel;
  logic outbev1, outbev2, outbev3, outquarter, outdime, outnickel;

  int checks = 0;
  int errors = 0;

  vending_machine dut (
    .clk(clk), .reset(reset),
    .inbev1(inbev1), .inbev2(inbev2), .inbev3(inbev3),
    .inquarter(inquarter), .indime(indime), .innickel(innickel),
    .outbev1(outbev1), .outbev2(outbev2), .outbev3(outbev3),
    .outquarter(outquarter), .outdime(outdime), .outnickel(outnickel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bev = {b1,b2,b3}, coin = {q,d,n}
  typedef struct {
    logic [2:0] bev;
    logic [2:0] coin;
    logic [2:0] exp_bev;
    logic [2:0] exp_chg;
    logic       chk_cr;
    logic [7:0] exp_cr;
  } vec_t;

  vec_t vecs[$];

  localparam logic [2:0] Z  = 3'b000;
  localparam logic [2:0] B1 = 3'b100, B2 = 3'b010, B3 = 3'b001;
  localparam logic [2:0] Q  = 3'b100, D  = 3'b010, N  = 3'b001;

  function automatic void add(input logic [2:0] bev, input logic [2:0] coin,
                              input logic [2:0] eb, input logic [2:0] ec,
                              input logic chk, input logic [7:0] cr);
    vec_t v;
    v.bev = bev; v.coin = coin; v.exp_bev = eb; v.exp_chg = ec; v.chk_cr = chk; v.exp_cr = cr;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input logic [2:0] bev, input logic [2:0] coin);
    {inbev1, inbev2, inbev3}       = bev;
    {inquarter, indime, innickel}  = coin;
  endtask

  task automatic step(input logic [2:0] bev, input logic [2:0] coin);
    drive(bev, coin);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [2:0] eb, input logic [2:0] ec);
    check({name, "_bev"}, {5'd0, outbev1, outbev2, outbev3}, {5'd0, eb});
    check({name, "_chg"}, {5'd0, outquarter, outdime, outnickel}, {5'd0, ec});
  endtask

  initial begin
    // 130 cents then bev2 -> dispense, one dime change
    add(Z, Q, Z, Z, 1'b0, 8'd0);  add(Z, N, Z, Z, 1'b0, 8'd0);
    add(Z, Q, Z, Z, 1'b0, 8'd0);  add(Z, D, Z, Z, 1'b0, 8'd0);
    add(Z, Q, Z, Z, 1'b0, 8'd0);  add(Z, D, Z, Z, 1'b0, 8'd0);
    add(Z, Q, Z, Z, 1'b0, 8'd0);  add(Z, N, Z, Z, 1'b1, 8'd130);
    add(B2, Z, Z, Z, 1'b0, 8'd0); add(Z, Z, B2, Z, 1'b1, 8'd0);
    add(Z, Z, Z, D, 1'b0, 8'd0);  add(Z, Z, Z, Z, 1'b1, 8'd0);
    // bev2 then reselect bev1 at 80, reach 115 -> bev1, dime, nickel
    add(B2, Z, Z, Z, 1'b0, 8'd0); add(Z, Q, Z, Z, 1'b0, 8'd0);
    add(Z, Q, Z, Z, 1'b0, 8'd0);  add(Z, N, Z, Z, 1'b0, 8'd0);
    add(Z, Q, Z, Z, 1'b1, 8'd80); add(B1, Z, Z, Z, 1'b0, 8'd0);
    add(Z, D, Z, Z, 1'b0, 8'd0);  add(Z, Q, Z, Z, 1'b1, 8'd115);
    add(Z, Z, B1, Z, 1'b0, 8'd0); add(Z, Z, Z, D, 1'b0, 8'd0);
    add(Z, Z, Z, N, 1'b0, 8'd0);  add(Z, Z, Z, Z, 1'b1, 8'd0);
    // bev3 exact 115 -> no change
    add(B3, Z, Z, Z, 1'b0, 8'd0); add(Z, Q, Z, Z, 1'b0, 8'd0);
    add(Z, Q, Z, Z, 1'b0, 8'd0);  add(Z, N, Z, Z, 1'b0, 8'd0);
    add(Z, Q, Z, Z, 1'b0, 8'd0);  add(Z, D, Z, Z, 1'b0, 8'd0);
    add(Z, Q, Z, Z, 1'b1, 8'd115); add(Z, Z, B3, Z, 1'b0, 8'd0);
    add(Z, Z, Z, Z, 1'b0, 8'd0);  add(Z, Z, Z, Z, 1'b1, 8'd0);
    // 125 with no selection holds, then bev1 -> quarter change
    for (int i = 0; i < 5; i++) add(Z, Q, Z, Z, 1'b0, 8'd0);
    add(Z, Z, Z, Z, 1'b0, 8'd0);  add(Z, Z, Z, Z, 1'b1, 8'd125);
    add(B1, Z, Z, Z, 1'b0, 8'd0); add(Z, Z, B1, Z, 1'b0, 8'd0);
    add(Z, Z, Z, Q, 1'b0, 8'd0);  add(Z, Z, Z, Z, 1'b1, 8'd0);
    // 150 then bev1 -> 50 change; nickel during change goes to credit
    for (int i = 0; i < 6; i++) add(Z, Q, Z, Z, 1'b0, 8'd0);
    add(B1, Z, Z, Z, 1'b1, 8'd150); add(Z, Z, B1, Z, 1'b0, 8'd0);
    add(Z, Z, Z, Q, 1'b0, 8'd0);  add(Z, N, Z, Q, 1'b1, 8'd5);
    add(Z, Z, Z, Z, 1'b1, 8'd5);

    drive(Z, Z);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", Z, Z);
    check("reset_credit", dut.r_credit, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].bev, vecs[i].coin);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_bev, vecs[i].exp_chg);
      if (vecs[i].chk_cr) check($sformatf("vec%0d_credit", i), dut.r_credit, vecs[i].exp_cr);
    end

    // Reset mid-CHANGE aborts pending change (credit 5 + 125 = 130, bev1 -> 30 change)
    for (int i = 0; i < 5; i++) step(Z, Q);
    step(B1, Z);
    step(Z, Z);
    check_outs("abort_disp", B1, Z);
    step(Z, Z);
    check_outs("abort_chg", Z, Q);
    #3;
    reset = 1'b0;
    #1;
    check_outs("abort_rst", Z, Z);
    check("abort_credit", dut.r_credit, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    step(Z, Z);
    check_outs("abort_after", Z, Z);
    step(Z, Z);
    check_outs("abort_after2", Z, Z);

    // Quarter and dime together
    step(Z, Q | D);
`ifdef VENDING_MULTI_COIN_EN
    check("multi_coin_credit", dut.r_credit, 8'd35);
`else
    check("multi_coin_credit", dut.r_credit, 8'd25);
`endif
    // Saturation at 255
    for (int i = 0; i < 10; i++) step(Z, Q);
    check("saturate_credit", dut.r_credit, 8'd255);
    // bev1 wins over bev2 when both pressed; 255-100 = 155 change starts with quarter
    step(B1 | B2, Z);
    check_outs("prio_sel", Z, Z);
    step(Z, Z);
    check_outs("prio_disp", B1, Z);
    step(Z, Z);
    check_outs("prio_chg", Z, Q);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
# vending_machine

Coin-operated three-beverage vending controller. Accepts quarter, dime and nickel inputs and latches a beverage selection. Once credit covers the selected price, it pulses one dispense output, then returns change one coin per cycle. It is a single-clock synchronous FSM that sits between the coin/button front end and the dispenser/coin-hopper actuators.

## Interface
- One clock; reset is asynchronous and active-low. The clock port is `clk` and the reset port is `reset`; `reset` low means in reset.
- Parameters:
  - `PRICE1`, default 100: price of beverage 1, in cents.
  - `PRICE2`, default 120: price of beverage 2, in cents.
  - `PRICE3`, default 115: price of beverage 3, in cents.
  - `CREDIT_W`, default 8: credit and change register width.
- Ports:
  - `clk`  in  1  system clock, rising edge.
  - `reset`  in  1  async active-low reset.
  - `inbev1` / `inbev2` / `inbev3`  in  1 each  beverage select requests, level-sampled.
  - `inquarter` / `indime` / `innickel`  in  1 each  coin inputs. Each cycle high counts as one coin of 25, 10 or 5 cents.
  - `outbev1` / `outbev2` / `outbev3`  out  1 each  dispense pulse, one cycle.
  - `outquarter` / `outdime` / `outnickel`  out  1 each  change coin pulse, one coin per cycle.

## Operation
- State registers:
  - `credit`: CREDIT_W bits, unsigned cents.
  - `sel`: NONE, B1, B2 or B3.
  - `change`: CREDIT_W bits.
  - FSM states: IDLE, DISPENSE, CHANGE.
- Coin accumulation, every cycle in every state:
  - `credit` += 25·inquarter + 10·indime + 5·innickel.
  - Credit saturates at 2^CREDIT_W−1; any excess is lost.
- Selection, every cycle in every state:
  - Any inbevN high overwrites `sel`; the most recent request wins.
  - If several are high in the same cycle, priority is bev1 > bev2 > bev3.
  - A new selection replaces the old one; credit is kept.
- IDLE:
  - If `sel` ≠ NONE and `credit` ≥ price(sel), go to DISPENSE.
  - On that edge: `change` ← credit − price, `credit` ← coins sampled this edge (normally 0), `sel` ← NONE unless a new request arrived this edge.
  - Otherwise stay in IDLE.
- DISPENSE:
  - outbevN matching the beverage being dispensed is high for exactly this cycle.
  - Next state is CHANGE if `change` > 0, else IDLE.
- CHANGE (greedy):
  - Assert outquarter if `change` ≥ 25; else outdime if ≥ 10; else outnickel.
  - Subtract the emitted coin's value each edge.
  - Go to IDLE on the edge where `change` reaches 0.
- Outputs are decoded from registered state and `change` only; they are glitch-free, with no combinational path from inputs.
- At most one outbev and at most one change coin output is high in any cycle.
- Credit never drops below 0; dispense only happens when funds are sufficient.

## Timing
- Reset (async assert, sync-safe release): all six outputs 0, credit 0, change 0, sel NONE, state IDLE.
- Reset asserted mid-DISPENSE or mid-CHANGE aborts immediately; pending change is discarded.
- Latency:
  - The coin or select is sampled at edge A.
  - The decision is taken at edge A+1.
  - outbevN is high during cycle A+1 to A+2.
  - The first change coin is high during cycle A+2 to A+3.
  - IDLE is re-entered one edge after the last change coin.
- Change duration = number of greedy coins. For example, 15 cents takes 2 cycles: dime then nickel.
- Coins inserted during DISPENSE or CHANGE go to `credit` for the next purchase. They never merge into `change`.
- A coin held high for N cycles counts N times.

## Configuration
- `VENDING_MULTI_COIN_EN` defined: coins asserted in the same cycle are all summed (e.g. quarter and dime together add 35).
- Not defined: only one coin is accepted per cycle, with priority quarter > dime > nickel. The lower-priority simultaneous coins are ignored and not credited.

## Test plan
- Reset, then 25, 5, 25, 10, 25, 10, 25, 5 (130), then bev2 pulse → outbev2 for 1 cycle, then outdime for 1 cycle, credit 0, IDLE.
- Select bev2, quarter held 2 cycles, then 5, 25 (80), reselect bev1, then 10, 25 (115) → outbev1, then outdime, then outnickel.
- Select bev3, then 50 (quarter held 2 cycles), 5, 25, 10, 25 (115) → outbev3 only, no change outputs, IDLE after 1 cycle.
- 125 cents with no selection → no outputs, credit holds 125. Then bev1 → outbev1, then outquarter.
- Nickel inserted during the CHANGE cycles → change is unaffected and credit is 5 on return to IDLE. Reset asserted during CHANGE → all outputs 0 immediately, credit 0.
- Quarter and dime in the same cycle → credit +35 with `VENDING_MULTI_COIN_EN`, +25 without it.
